sni_bitap_matcher: RTL
======================

# sni_bitap_matcher

Parametrised, programmable Shift-And (bitap) SNI pattern matcher for the encrypted-traffic identification path. It consumes LANES bytes per cycle of an SNI byte stream and looks each byte up in a runtime-writable mask RAM. Per record it reports a hit flag and the byte offset of the first match. It generalises the fixed-pattern 2-byte matchers: pattern length and lane count are parameters, the pattern is programmable, wildcard gaps are supported, partial beats are accepted, and results are framed per record.

## Interface
- LANES, 2, bytes per beat (1–8)
- PAT_LEN, 16, maximum pattern positions (2–32)
- OFFSET_W, 16, width of byte-offset counter
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_match_data_valid  in  1  beat valid; no backpressure
- i_match_data  in  8*LANES  lane 0 = bits [8*LANES-1 -: 8] = earliest byte
- i_match_data_keep  in  LANES  lane enables, contiguous from lane 0
- i_match_data_last  in  1  final beat of record
- i_cfg_wr_en  in  1  mask RAM write strobe
- i_cfg_wr_addr  in  8  byte value
- i_cfg_wr_data  in  PAT_LEN  bit k = 1: byte matches position k
- i_cfg_gap  in  PAT_LEN  bit k = 1: any run of ≥0 bytes may follow position k (quasi-static)
- i_cfg_last_pos  in  $clog2(PAT_LEN)  final pattern position (quasi-static)
- o_match  out  1  pulse: a match ended in this beat
- o_result_valid  out  1  pulse: record finished
- o_result_hit  out  1  record contained ≥1 match
- o_result_offset  out  OFFSET_W  end-byte index of first match (0 if no hit)

## Operation
- State vector D[PAT_LEN-1:0] is active-high. For each kept byte c in lane order: D = (((D<<1)|1) & M[c]) | (D & G). G is i_cfg_gap with bit i_cfg_last_pos forced to 0. The search is unanchored: bit 0 is injected on every byte.
- A lane matches when its post-update D[i_cfg_last_pos] = 1.
- Lanes are chained combinationally within one beat. Lanes that are not kept pass D through unchanged and do not advance the offset.
- The byte counter counts kept bytes from record start, starting at 0, and saturates at 2^OFFSET_W-1.
- The first matching lane in a record latches its byte index. Later matches do not overwrite it.
- On the last beat:
  - Results are emitted.
  - D, the counter and the hit/offset latches are cleared.
  - The next record starts clean on the following beat.
- Mask RAM:
  - Has 256 × PAT_LEN entries.
  - Has one write port and LANES registered read ports. The read ports are identical copies written together.
  - Read-first: a beat issued in the same cycle as a write to the same address sees the old data.
  - Power-up content is 0. The RAM is not cleared by i_rst.
- There is no state machine beyond a two-stage pipeline: address register/RAM read, then state update.

## Timing
- Beat at cycle N → o_match at N+2. For a last beat at N, o_result_valid/hit/offset appear at N+2.
- o_result_* hold their values until the next o_result_valid.
- Invalid cycles freeze D and the counter.
- A beat with keep = 0 and last = 1 still closes the record.
- Reset value of every output is 0. Reset also clears D, the counter, the latches and the pipeline valids.
- Reset mid-record drops the record with no o_result_valid. Beats already in flight are discarded.
- Configuration writes take effect for beats issued ≥1 cycle after the write.
- i_cfg_gap and i_cfg_last_pos may change only between records.

## Structure
- Package sni_match_pkg: SNI_BYTE_W = 8, MASK_DEPTH = 256, and the lane-ordering helper function.
- Sub-module sni_mask_ram: one write port, LANES registered read ports, read-first behaviour, parametrised width.
- The core is the lane-chain update, the counter, the latches and the output registers.

## Test plan
- **Basic match.** LANES=2, pattern "smtps" (last_pos=4, gap=0), record "xsmtps" over 3 beats with last on beat 3 → o_match on beat 3 +2; result hit=1, offset=5.
- **Cross-beat and repeat.** Same pattern, "smsmtpssmtps" → o_match pulses twice; offset=6.
- **Gap.** Pattern "a*b" (positions a, b; gap[0]=1, last_pos=1), stream "zaqqqqb" → hit, offset=6. Stream "bqa" → hit=0, offset=0.
- **Partial beat.** keep=2'b10 on the final beat with "s" completing "smtp"+"s" → offset counts only kept bytes. The dropped lane 1 byte does not affect D.
- **Reset mid-record.** Assert i_rst after 2 beats of "smt", then send "ps" with last → hit=0 and no earlier result_valid.
- **Config collision.** Write M['s'] = 0 in the same cycle as a beat containing 's' → that beat uses the old mask. The next record containing "smtps" gives hit=0.

Source files
------------

// File: rtl/sni_match_pkg.sv
// sni_match_pkg: shared constants and lane-ordering helper for the SNI bitap matcher.
package sni_match_pkg;
   localparam int SNI_BYTE_W = 8;
   localparam int MASK_DEPTH = 256;
   // Lane 0 is the earliest byte and sits in the most significant byte of the beat.
   function automatic int lane_lsb(input int lanes, input int lane);
      return SNI_BYTE_W * (lanes - 1 - lane);
   endfunction
endpackage

// File: rtl/sni_mask_ram.sv
// sni_mask_ram: byte-indexed mask RAM, one write port, LANES registered read-first read ports.
module sni_mask_ram
   import sni_match_pkg::*;
#(
   parameter int LANES = 2,
   parameter int WIDTH = 16
) (
   input  logic                        i_clk,
   input  logic                        i_wr_en,
   input  logic [SNI_BYTE_W-1:0]       i_wr_addr,
   input  logic [WIDTH-1:0]            i_wr_data,
   input  logic [SNI_BYTE_W*LANES-1:0] i_rd_addr,
   output logic [WIDTH*LANES-1:0]      o_rd_data
);
   for (genvar l = 0; l < LANES; l++) begin : g_port
      logic [WIDTH-1:0] mem [MASK_DEPTH];
      logic [WIDTH-1:0] rd_d;
      logic [WIDTH-1:0] rd_q;
      always_comb rd_d = mem[i_rd_addr[l*SNI_BYTE_W +: SNI_BYTE_W]];
      always_ff @(posedge i_clk) begin
         if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
         rd_q <= rd_d;
      end
      assign o_rd_data[l*WIDTH +: WIDTH] = rd_q;
   end
endmodule

// File: rtl/sni_bitap_matcher.sv
// sni_bitap_matcher: programmable multi-lane Shift-And SNI matcher with per-record hit/offset results.
module sni_bitap_matcher
   import sni_match_pkg::*;
#(
   parameter int LANES    = 2,
   parameter int PAT_LEN  = 16,
   parameter int OFFSET_W = 16,
   localparam int LPW     = $clog2(PAT_LEN)
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_match_data_valid,
   input  logic [SNI_BYTE_W*LANES-1:0] i_match_data,
   input  logic [LANES-1:0]            i_match_data_keep,
   input  logic                        i_match_data_last,
   input  logic                        i_cfg_wr_en,
   input  logic [SNI_BYTE_W-1:0]       i_cfg_wr_addr,
   input  logic [PAT_LEN-1:0]          i_cfg_wr_data,
   input  logic [PAT_LEN-1:0]          i_cfg_gap,
   input  logic [LPW-1:0]              i_cfg_last_pos,
   output logic                        o_match,
   output logic                        o_result_valid,
   output logic                        o_result_hit,
   output logic [OFFSET_W-1:0]         o_result_offset
);
   logic [SNI_BYTE_W*LANES-1:0] rd_addr;
   logic [PAT_LEN*LANES-1:0]    mask;
   logic [PAT_LEN-1:0]          gap;
   logic                        v1_d, v1_q, last1_d, last1_q;
   logic [LANES-1:0]            keep1_d, keep1_q;
   logic [PAT_LEN-1:0]          st_d, st_q;
   logic [OFFSET_W-1:0]         cnt_d, cnt_q, off_d, off_q, res_off_d, res_off_q;
   logic                        hit_d, hit_q, match_d, match_q;
   logic                        res_valid_d, res_valid_q, res_hit_d, res_hit_q;

   always_comb begin
      rd_addr = '0;
      for (int i = 0; i < LANES; i++)
         rd_addr[i*SNI_BYTE_W +: SNI_BYTE_W] = i_match_data[lane_lsb(LANES, i) +: SNI_BYTE_W];
   end

   sni_mask_ram #(.LANES(LANES), .WIDTH(PAT_LEN)) u_ram (
      .i_clk     (i_clk),
      .i_wr_en   (i_cfg_wr_en),
      .i_wr_addr (i_cfg_wr_addr),
      .i_wr_data (i_cfg_wr_data),
      .i_rd_addr (rd_addr),
      .o_rd_data (mask)
   );

   // The final position never self-loops, otherwise a match would repeat on every later byte.
   assign gap = i_cfg_gap & ~(PAT_LEN'(1) << i_cfg_last_pos);

   always_comb begin
      v1_d        = i_match_data_valid;
      keep1_d     = i_match_data_keep;
      last1_d     = i_match_data_last;
      st_d        = st_q;
      cnt_d       = cnt_q;
      hit_d       = hit_q;
      off_d       = off_q;
      match_d     = 1'b0;
      res_valid_d = 1'b0;
      res_hit_d   = res_hit_q;
      res_off_d   = res_off_q;
      if (v1_q) begin
         for (int i = 0; i < LANES; i++) begin
            if (keep1_q[LANES-1-i]) begin
               st_d = ({st_d[PAT_LEN-2:0], 1'b1} & mask[i*PAT_LEN +: PAT_LEN]) | (st_d & gap);
               if (st_d[i_cfg_last_pos]) begin
                  match_d = 1'b1;
                  off_d   = hit_d ? off_d : cnt_d;
                  hit_d   = 1'b1;
               end
               cnt_d = (&cnt_d) ? cnt_d : cnt_d + 1'b1;
            end
         end
         if (last1_q) begin
            res_valid_d = 1'b1;
            res_hit_d   = hit_d;
            res_off_d   = off_d;
            st_d        = '0;
            cnt_d       = '0;
            hit_d       = 1'b0;
            off_d       = '0;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         v1_q        <= 1'b0;
         keep1_q     <= '0;
         last1_q     <= 1'b0;
         st_q        <= '0;
         cnt_q       <= '0;
         hit_q       <= 1'b0;
         off_q       <= '0;
         match_q     <= 1'b0;
         res_valid_q <= 1'b0;
         res_hit_q   <= 1'b0;
         res_off_q   <= '0;
      end else begin
         v1_q        <= v1_d;
         keep1_q     <= keep1_d;
         last1_q     <= last1_d;
         st_q        <= st_d;
         cnt_q       <= cnt_d;
         hit_q       <= hit_d;
         off_q       <= off_d;
         match_q     <= match_d;
         res_valid_q <= res_valid_d;
         res_hit_q   <= res_hit_d;
         res_off_q   <= res_off_d;
      end
   end

   assign o_match         = match_q;
   assign o_result_valid  = res_valid_q;
   assign o_result_hit    = res_hit_q;
   assign o_result_offset = res_off_q;
endmodule
